// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states, default memory span.
// Latency: no logic here. Backpressure: no logic here.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned MEM_BYTES_DEFAULT = 120;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_WR     = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  // Size code 11 counts as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: extracts and extends load lanes, merges store lanes into a word.
// Latency: purely combinational. Backpressure: none.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    // Offset 0 is the most significant lane, so the shift is (3 - offset) bytes.
    bsh     = {~offset, 3'b000};
    hsh     = {~offset[1], 4'b0000};
    b       = word[bsh +: 8];
    h       = word[hsh +: 16];
    ld_val  = word;
    st_word = wdata;
    case (size)
      SZ_BYTE: begin
        ld_val           = {{24{sign_ext & b[7]}}, b};
        st_word          = word;
        st_word[bsh +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_val             = {{16{sign_ext & h[15]}}, h};
        st_word            = word;
        st_word[hsh +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end onto a word-only memory port; errors done in 1 cycle, loads/sw in 2, sb/sh (RMW) in 3.
// Backpressure: req is only sampled in IDLE; anything presented while busy is dropped, nothing is queued.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_align,
  output logic        err_range,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [31:0] m_dout
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic        ealign_q;
  logic        erange_q;

  logic        mis;
  logic        oor;
  logic [32:0] end_addr;
  logic        sub_word;
  logic [31:0] lane_word;
  logic [31:0] ld_val;
  logic [31:0] st_word;

  always_comb begin
    end_addr = {1'b0, addr} + {30'b0, size_bytes(size)};
    oor      = end_addr > 33'(MEM_BYTES);
    sub_word = (size == SZ_BYTE) || (size == SZ_HALF);
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr[0];
      default: mis = |addr[1:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (mis || oor)  state_nxt = S_RESP;
          else if (!we)    state_nxt = S_RD;
          else if (sub_word) state_nxt = S_RMW_RD;
          else             state_nxt = S_WR;
        end
      end
      S_RD:     state_nxt = S_RESP;
      S_RMW_RD: state_nxt = S_RMW_WR;
      S_RMW_WR: state_nxt = S_RESP;
      S_WR:     state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Loads extract straight from the port in RD so rdata is already valid during RESP.
  assign lane_word = (state == S_RD) ? m_dout : word_q;

  mem_lane_align u_lane (
    .word     (lane_word),
    .offset   (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .wdata    (wdata_q),
    .ld_val   (ld_val),
    .st_word  (st_word)
  );

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_RESP);
    err_align = (state == S_RESP) && ealign_q;
    err_range = (state == S_RESP) && erange_q;
    m_rd      = (state == S_RD) || (state == S_RMW_RD);
    m_wr      = (state == S_WR) || (state == S_RMW_WR);
    m_addr    = {addr_q[31:2], 2'b00};
    m_din     = '0;
    if (state == S_WR)     m_din = wdata_q;
    if (state == S_RMW_WR) m_din = st_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      ealign_q <= 1'b0;
      erange_q <= 1'b0;
      rdata    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        size_q   <= size;
        sign_q   <= sign_ext;
        ealign_q <= mis;
        erange_q <= oor;
      end
      if (state == S_RD || state == S_RMW_RD) word_q <= m_dout;
      if (state == S_RD) rdata <= ld_val;
    end
  end

endmodule
